// File: rtl/tree_pkg.sv
// Shared types and elaboration helpers for the counter-tree layer blocks.
package tree_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int tree_total(input int num_counter, input int num_slice);
    return num_counter * num_slice;
  endfunction

  function automatic int tree_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/tree_layer_ram.sv
// Simple dual-port layer RAM: port A writes, port B reads registered and read-first.
module tree_layer_ram #(
  parameter int DATA_W = 3,
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Wr_En,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [DATA_W-1:0] Wr_Data,
  input  logic [ADDR_W-1:0] Rd_Addr,
  output logic [DATA_W-1:0] Rd_Data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Array contents are never reset; only the read register is.
  always_ff @(posedge Clk) begin
    if (Wr_En) mem[Wr_Addr] <= Wr_Data;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) Rd_Data <= '0;
    else          Rd_Data <= mem[Rd_Addr];
  end

endmodule

// File: rtl/tree_layer_splitter.sv
// Tree layer: keeps the low DIV_BITS of each counter in RAM and sums the high
// parts over groups of GROUP counters into saturating parent counters.
module tree_layer_splitter
  import tree_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int DIV_BITS    = 3,
  parameter int NUM_COUNTER = 10,
  parameter int NUM_SLICE   = 3,
  parameter int GROUP       = 3,
  parameter int ADDR_W      = 10,
  parameter int PAR_W       = 32
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Start,
  input  logic                In_Valid,
  input  logic [CNT_W-1:0]    In_Counter,
  output logic                In_Ready,
  output logic                Par_Valid,
  output logic [PAR_W-1:0]    Par_Counter,
  input  logic                Par_Ready,
  input  logic [ADDR_W-1:0]   Rd_Addr,
  output logic [DIV_BITS-1:0] Rd_Data,
  output logic                Busy,
  output logic                Done,
  output logic                Ovf
);

  localparam int TOTAL  = tree_total(NUM_COUNTER, NUM_SLICE);
  localparam int GCNT_W = (tree_clog2(GROUP) < 1) ? 1 : tree_clog2(GROUP);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TOTAL - 1);
  localparam logic [GCNT_W-1:0] LAST_GRP = GCNT_W'(GROUP - 1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   idx;
  logic [GCNT_W-1:0]   gcnt;
  logic [PAR_W-1:0]    acc;
  logic                par_vld_p1;
  logic [PAR_W-1:0]    par_cnt_p1;
  logic                ovf_q;
  logic                beat;
  logic                last_beat;
  logic                grp_end;
  logic [PAR_W:0]      hi_part;
  logic [PAR_W-1:0]    sum_sat;
  logic                sum_ovf;

  // Returns {saturated, value}; a carry out of PAR_W bits clamps to all ones.
  function automatic logic [PAR_W:0] sat_add(input logic [PAR_W-1:0] a,
                                             input logic [PAR_W:0]   b);
    logic [PAR_W+1:0] s;
    s = {2'b00, a} + {1'b0, b};
    if (s[PAR_W+1:PAR_W] != 2'b00) return {1'b1, {PAR_W{1'b1}}};
    return {1'b0, s[PAR_W-1:0]};
  endfunction

  always_comb begin
    hi_part            = (PAR_W+1)'(In_Counter >> DIV_BITS);
    {sum_ovf, sum_sat} = sat_add(acc, hi_part);
    In_Ready           = (state == RUN) && (!par_vld_p1 || Par_Ready);
    beat               = In_Valid && In_Ready;
    last_beat          = beat && (idx == LAST_IDX);
    grp_end            = (gcnt == LAST_GRP) || (idx == LAST_IDX);
  end

  always_comb begin
    state_nxt = state;
    if (Start) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN:     if (last_beat) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Stage p1: accumulate high parts; a group boundary loads the parent register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      idx        <= '0;
      gcnt       <= '0;
      acc        <= '0;
      par_vld_p1 <= 1'b0;
      par_cnt_p1 <= '0;
      ovf_q      <= 1'b0;
    end else if (Start) begin
      idx        <= '0;
      gcnt       <= '0;
      acc        <= '0;
      par_vld_p1 <= 1'b0;
      par_cnt_p1 <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (par_vld_p1 && Par_Ready) begin
        par_vld_p1 <= 1'b0;
        par_cnt_p1 <= '0;
      end
      if (beat) begin
        idx <= idx + ADDR_W'(1);
        if (sum_ovf) ovf_q <= 1'b1;
        if (grp_end) begin
          par_vld_p1 <= 1'b1;
          par_cnt_p1 <= sum_sat;
          acc        <= '0;
          gcnt       <= '0;
        end else begin
          acc  <= sum_sat;
          gcnt <= gcnt + GCNT_W'(1);
        end
      end
    end
  end

  tree_layer_ram #(
    .DATA_W (DIV_BITS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Wr_En   (beat),
    .Wr_Addr (idx),
    .Wr_Data (In_Counter[DIV_BITS-1:0]),
    .Rd_Addr (Rd_Addr),
    .Rd_Data (Rd_Data)
  );

  assign Par_Valid   = par_vld_p1;
  assign Par_Counter = par_cnt_p1;
  assign Busy        = (state == RUN);
  assign Done        = (state == DONE) && !par_vld_p1;
  assign Ovf         = ovf_q;

endmodule

// File: tb/tb_tree_layer_splitter.sv
// Bench for tree_layer_splitter: unit 0 uses defaults (TOTAL=30, PAR_W=32),
// unit 1 uses NUM_SLICE=1 and PAR_W=5 (TOTAL=10) to reach partial groups and saturation.
module tb_tree_layer_splitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  start, in_valid, par_ready;
  logic [1:0]  in_ready, par_valid, busy, done, ovf;
  logic [31:0] in_cnt [2];
  logic [9:0]  rd_addr [2];
  logic [2:0]  rd_data_a, rd_data_b;
  logic [31:0] par_cnt_a;
  logic [4:0]  par_cnt_b;

  tree_layer_splitter dut_a (
    .Clk(clk), .Reset_n(rst_n), .Start(start[0]), .In_Valid(in_valid[0]),
    .In_Counter(in_cnt[0]), .In_Ready(in_ready[0]), .Par_Valid(par_valid[0]),
    .Par_Counter(par_cnt_a), .Par_Ready(par_ready[0]), .Rd_Addr(rd_addr[0]),
    .Rd_Data(rd_data_a), .Busy(busy[0]), .Done(done[0]), .Ovf(ovf[0])
  );

  tree_layer_splitter #(.NUM_SLICE(1), .PAR_W(5)) dut_b (
    .Clk(clk), .Reset_n(rst_n), .Start(start[1]), .In_Valid(in_valid[1]),
    .In_Counter(in_cnt[1]), .In_Ready(in_ready[1]), .Par_Valid(par_valid[1]),
    .Par_Counter(par_cnt_b), .Par_Ready(par_ready[1]), .Rd_Addr(rd_addr[1]),
    .Rd_Data(rd_data_b), .Busy(busy[1]), .Done(done[1]), .Ovf(ovf[1])
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] stim[$];
  logic [31:0] sent[$];
  longint      got_a[$], got_b[$], expq[$];
  bit          exp_ovf;
  logic [2:0]  ram_a [30];
  logic [2:0]  ram_b [10];

  function automatic int tot(input int u);  return (u == 1) ? 10 : 30; endfunction
  function automatic int parw(input int u); return (u == 1) ? 5 : 32;  endfunction
  function automatic logic [63:0] pc(input int u);
    return (u == 1) ? 64'(par_cnt_b) : 64'(par_cnt_a);
  endfunction
  function automatic logic [63:0] rd(input int u);
    return (u == 1) ? 64'(rd_data_b) : 64'(rd_data_a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Handshake completes at the posedge between the #1 sample and the next negedge.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && par_valid[0] && par_ready[0]) got_a.push_back(longint'(par_cnt_a));
    if (rst_n && par_valid[1] && par_ready[1]) got_b.push_back(longint'(par_cnt_b));
  end

  task automatic send(input int u, input logic [31:0] v);
    bit took = 0;
    int n = 0;
    in_valid[u] = 1'b1;
    in_cnt[u]   = v;
    while (!took && n < 200) begin
      #1 took = in_ready[u];
      @(negedge clk);
      n++;
    end
    in_valid[u] = 1'b0;
    if (!took) chk("send_timeout", 0, 1);
    else begin
      if (u == 1) ram_b[sent.size()] = v[2:0];
      else        ram_a[sent.size()] = v[2:0];
      sent.push_back(v);
    end
  endtask

  task automatic begin_frame(input int u);
    start[u] = 1'b1;
    @(negedge clk);
    start[u] = 1'b0;
    sent.delete();
    if (u == 1) got_b.delete(); else got_a.delete();
  endtask

  task automatic wait_done(input int u);
    int n = 0;
    while (!done[u] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", done[u], 1);
    chk("busy_after_done", busy[u], 0);
  endtask

  // Parent j = min(2^PAR_W-1, sum of truncated high parts of its children).
  task automatic build_exp(input int u);
    longint s, maxv, mask;
    maxv = (64'sd1 <<< parw(u)) - 1;
    mask = (64'sd1 <<< (parw(u) + 1)) - 1;
    expq.delete();
    exp_ovf = 1'b0;
    for (int g = 0; g * 3 < sent.size(); g++) begin
      s = 0;
      for (int i = g * 3; i < g * 3 + 3 && i < sent.size(); i++)
        s += (longint'(sent[i]) >> 3) & mask;
      if (s > maxv) begin
        s = maxv;
        exp_ovf = 1'b1;
      end
      expq.push_back(s);
    end
  endtask

  task automatic check_frame(input int u, input string tag);
    longint q[$];
    build_exp(u);
    if (u == 1) q = got_b; else q = got_a;
    chk({tag, "_npar"}, 64'(q.size()), 64'(expq.size()));
    for (int i = 0; i < q.size() && i < expq.size(); i++)
      chk($sformatf("%s_par%0d", tag, i), q[i], expq[i]);
    chk({tag, "_ovf"}, ovf[u], exp_ovf);
  endtask

  task automatic check_ram(input int u, input string tag);
    for (int i = 0; i < tot(u); i++) begin
      rd_addr[u] = 10'(i);
      @(negedge clk);
      if (u == 1) chk($sformatf("%s_ram%0d", tag, i), rd(u), 64'(ram_b[i]));
      else        chk($sformatf("%s_ram%0d", tag, i), rd(u), 64'(ram_a[i]));
    end
  endtask

  task automatic drive(input int u, input bit toggle);
    bit stop = 0;
    fork
      begin
        foreach (stim[i]) send(u, stim[i]);
        wait_done(u);
        stop = 1;
      end
      begin
        while (toggle && !stop) begin
          @(negedge clk);
          par_ready[u] = 1'($urandom_range(0, 1));
        end
        par_ready[u] = 1'b1;
      end
    join
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    rst_n = 1'b0; start = '0; in_valid = '0; par_ready = 2'b11;
    in_cnt[0] = '0; in_cnt[1] = '0; rd_addr[0] = '0; rd_addr[1] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready[0], 0);
    chk("rst_par_valid", par_valid[0], 0);
    chk("rst_par_cnt", pc(0), 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_ovf", ovf[0], 0);
    chk("rst_rd_data", rd(0), 0);

    // All-13 frame: every parent is 3*(13>>3) = 3, RAM holds 13&7 = 5.
    begin_frame(0);
    chk("s1_busy", busy[0], 1);
    for (int i = 0; i < 30; i++) send(0, 32'd13);
    chk("s1_done_early", done[0], 0);
    @(negedge clk);
    chk("s1_done_2cyc", done[0], 1);
    check_frame(0, "s1");
    chk("s1_par_value", got_a.size() > 0 ? got_a[0] : -1, 3);
    check_ram(0, "s1");

    // Read-first: address 4 holds 5, the beat writes 9&7 = 1 there.
    begin_frame(0);
    for (int i = 0; i < 4; i++) send(0, $urandom());
    rd_addr[0] = 10'd4;
    send(0, 32'd9);
    chk("rf_old", rd(0), 5);
    @(negedge clk);
    chk("rf_new", rd(0), 1);
    for (int i = 5; i < 30; i++) send(0, $urandom());
    wait_done(0);
    check_frame(0, "rf");
    check_ram(0, "rf");

    // Downstream stalls on the first parent for five cycles.
    stim.delete();
    for (int i = 0; i < 30; i++) stim.push_back($urandom());
    par_ready[0] = 1'b0;
    begin_frame(0);
    fork
      foreach (stim[i]) send(0, stim[i]);
      begin
        int n = 0;
        while (!par_valid[0] && n < 200) begin
          @(negedge clk); #2; n++;
        end
        chk("stall_pv", par_valid[0], 1);
        held = par_cnt_a;
        repeat (5) begin
          @(negedge clk); #2;
          chk("stall_in_ready", in_ready[0], 0);
          chk("stall_hold", 64'(par_cnt_a), 64'(held));
        end
        @(negedge clk);
        par_ready[0] = 1'b1;
      end
    join
    wait_done(0);
    check_frame(0, "stall");

    // Random data with random downstream backpressure.
    stim.delete();
    for (int i = 0; i < 30; i++) stim.push_back($urandom());
    begin_frame(0);
    drive(0, 1'b1);
    check_frame(0, "rnd");
    check_ram(0, "rnd");

    // Abort with a parent pending, then a complete fresh frame.
    begin_frame(0);
    for (int i = 0; i < 5; i++) send(0, $urandom());
    par_ready[0] = 1'b0;
    send(0, $urandom());
    chk("abort_pending", par_valid[0], 1);
    begin_frame(0);
    chk("abort_pv_dropped", par_valid[0], 0);
    chk("abort_busy", busy[0], 1);
    stim.delete();
    for (int i = 0; i < 30; i++) stim.push_back($urandom());
    drive(0, 1'b0);
    check_frame(0, "abort");
    check_ram(0, "abort");

    // Unit 1: inputs k*8 give parents 3, 12, 21 and a partial 9.
    stim.delete();
    for (int i = 0; i < 10; i++) stim.push_back(32'(i * 8));
    begin_frame(1);
    drive(1, 1'b0);
    check_frame(1, "k8");
    chk("k8_npar_const", 64'(got_b.size()), 4);
    chk("k8_last_partial", got_b.size() == 4 ? got_b[3] : -1, 9);

    // Unit 1 saturation: every parent clamps to 31, RAM holds 7.
    begin_frame(1);
    send(1, 32'hFFFF_FFFF);
    chk("sat_ovf_first", ovf[1], 1);
    for (int i = 1; i < 10; i++) send(1, 32'hFFFF_FFFF);
    wait_done(1);
    check_frame(1, "sat");
    chk("sat_par_value", got_b.size() > 0 ? got_b[0] : -1, 31);
    check_ram(1, "sat");

    begin_frame(1);
    chk("sat_ovf_cleared", ovf[1], 0);
    stim.delete();
    for (int i = 0; i < 10; i++) stim.push_back(32'($urandom_range(0, 255)));
    drive(1, 1'b1);
    check_frame(1, "rnd_b");

    // Asynchronous reset in the middle of a frame with a parent pending.
    begin_frame(0);
    par_ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) send(0, 32'd100);
    chk("arst_pending", par_valid[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_par_valid", par_valid[0], 0);
    chk("arst_par_cnt", pc(0), 0);
    chk("arst_in_ready", in_ready[0], 0);
    chk("arst_busy", busy[0], 0);
    chk("arst_done", done[0], 0);
    chk("arst_rd_data", rd(0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    par_ready[0] = 1'b1;
    in_valid[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_idle_in_ready", in_ready[0], 0);
    chk("arst_idle_busy", busy[0], 0);
    in_valid[0] = 1'b0;
    begin_frame(0);
    chk("arst_restart_ready", in_ready[0], 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
